// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Requester-side controller for the M-extension divide ops (DIV/DIVU/REM/REMU).
// It converts signed operands to magnitudes and drives an unsigned iterative
// divider through a start / operand / done-pulse handshake. RISC-V corner cases
// (divide by zero, signed overflow, zero dividend) are answered locally without
// starting the divider. The execute stage is stalled until the result is ready.
//
// Optional feature: define DIV_REM_FUSE_EN to keep the last divider result
// (quotient, remainder, operands, signedness). A following DIV/REM on the same
// operands is then answered from that cache in one cycle.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        rst,              // asynchronous, active-low
    input  logic        req_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] result,
    output logic        div_start,
    output logic [31:0] div_numerator,
    output logic [31:0] div_denominator,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_resp
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of a signed operand; unsigned operands pass through.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

    // Pick quotient or remainder and restore the sign removed before division.
    function automatic logic [31:0] sign_fix(
        input logic        sel_rem,
        input logic        neg_quo,
        input logic        neg_rem,
        input logic [31:0] quo,
        input logic [31:0] rem
    );
        logic [31:0] res;
        if (sel_rem) begin
            res = neg_rem ? neg32(rem) : rem;
        end else begin
            res = neg_quo ? neg32(quo) : quo;
        end
        return res;
    endfunction

    state_e      state_q, state_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] num_q, num_d;
    logic [31:0] den_q, den_d;
    logic [31:0] result_q, result_d;

    logic        op_valid_s;
    logic        is_signed_s;
    logic        is_rem_s;
    logic        neg_quo_s;
    logic        neg_rem_s;
    logic [31:0] mag1_s;
    logic [31:0] mag2_s;
    logic        accept_s;
    logic        special_s;
    logic [31:0] special_result_s;
    logic        hit_s;
    logic [31:0] hit_result_s;

    // Decode the incoming op: signedness, result select, sign-fix flags, magnitudes.
    always_comb begin
        op_valid_s  = funct3[2];
        is_signed_s = ~funct3[0];
        is_rem_s    = funct3[1];
        neg_quo_s   = is_signed_s & (rs1[31] ^ rs2[31]);
        neg_rem_s   = is_signed_s & rs1[31];
        mag1_s      = mag32(rs1, is_signed_s);
        mag2_s      = mag32(rs2, is_signed_s);
        accept_s    = (state_q == ST_IDLE) && req_valid && op_valid_s && !flush;
    end

    // Corner cases answered without the divider; divide-by-zero takes priority.
    always_comb begin
        special_s        = 1'b0;
        special_result_s = 32'd0;
        if (rs2 == 32'd0) begin
            special_s        = 1'b1;
            special_result_s = is_rem_s ? rs1 : 32'hFFFF_FFFF;
        end else if (is_signed_s && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF)) begin
            special_s        = 1'b1;
            special_result_s = is_rem_s ? 32'd0 : 32'h8000_0000;
        end else if (rs1 == 32'd0) begin
            special_s        = 1'b1;
            special_result_s = 32'd0;
        end else begin
            special_s        = 1'b0;
            special_result_s = 32'd0;
        end
    end

`ifdef DIV_REM_FUSE_EN
    logic        cache_valid_q, cache_valid_d;
    logic        cache_signed_q, cache_signed_d;
    logic [31:0] cache_rs1_q, cache_rs1_d;
    logic [31:0] cache_rs2_q, cache_rs2_d;
    logic [31:0] cache_quo_q, cache_quo_d;
    logic [31:0] cache_rem_q, cache_rem_d;
    // Key of the op currently in flight, written into the cache when it completes.
    logic        key_signed_q, key_signed_d;
    logic [31:0] key_rs1_q, key_rs1_d;
    logic [31:0] key_rs2_q, key_rs2_d;

    // Cache next state: latch the in-flight key, fill on a normal result, drop on flush while dividing.
    always_comb begin
        key_signed_d   = accept_s ? is_signed_s : key_signed_q;
        key_rs1_d      = accept_s ? rs1 : key_rs1_q;
        key_rs2_d      = accept_s ? rs2 : key_rs2_q;
        cache_valid_d  = cache_valid_q;
        cache_signed_d = cache_signed_q;
        cache_rs1_d    = cache_rs1_q;
        cache_rs2_d    = cache_rs2_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        if ((state_q == ST_WAIT) && div_resp && !flush) begin
            cache_valid_d  = 1'b1;
            cache_signed_d = key_signed_q;
            cache_rs1_d    = key_rs1_q;
            cache_rs2_d    = key_rs2_q;
            cache_quo_d    = div_quotient;
            cache_rem_d    = div_remainder;
        end else if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && flush) begin
            cache_valid_d  = 1'b0;
        end else begin
            cache_valid_d  = cache_valid_q;
        end
    end

    // Cache and in-flight key registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_rs1_q    <= 32'd0;
            cache_rs2_q    <= 32'd0;
            cache_quo_q    <= 32'd0;
            cache_rem_q    <= 32'd0;
            key_signed_q   <= 1'b0;
            key_rs1_q      <= 32'd0;
            key_rs2_q      <= 32'd0;
        end else begin
            cache_valid_q  <= cache_valid_d;
            cache_signed_q <= cache_signed_d;
            cache_rs1_q    <= cache_rs1_d;
            cache_rs2_q    <= cache_rs2_d;
            cache_quo_q    <= cache_quo_d;
            cache_rem_q    <= cache_rem_d;
            key_signed_q   <= key_signed_d;
            key_rs1_q      <= key_rs1_d;
            key_rs2_q      <= key_rs2_d;
        end
    end

    assign hit_s = cache_valid_q && (rs1 == cache_rs1_q) && (rs2 == cache_rs2_q) &&
                   (is_signed_s == cache_signed_q);
    assign hit_result_s = sign_fix(is_rem_s, neg_quo_s, neg_rem_s, cache_quo_q, cache_rem_q);
`else
    assign hit_s        = 1'b0;
    assign hit_result_s = 32'd0;
`endif

    // Controller next state: accept, issue, wait for the divider, drain after a flush, respond.
    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        num_d     = num_q;
        den_d     = den_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    is_rem_d  = is_rem_s;
                    neg_quo_d = neg_quo_s;
                    neg_rem_d = neg_rem_s;
                    num_d     = mag1_s;
                    den_d     = mag2_s;
                    if (special_s) begin
                        result_d = special_result_s;
                        state_d  = ST_RESP;
                    end else if (hit_s) begin
                        result_d = hit_result_s;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The start pulse has already gone out, so a flush must drain it.
                if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    // A done pulse coinciding with the flush is consumed and discarded.
                    state_d = div_resp ? ST_IDLE : ST_DRAIN;
                end else if (div_resp) begin
                    result_d = sign_fix(is_rem_q, neg_quo_q, neg_rem_q, div_quotient, div_remainder);
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (div_resp) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, captured operand info and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            num_q     <= 32'd0;
            den_q     <= 32'd0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            num_q     <= num_d;
            den_q     <= den_d;
            result_q  <= result_d;
        end
    end

    // A flush in the response cycle kills the response.
    assign resp_valid      = (state_q == ST_RESP) && !flush;
    assign result          = resp_valid ? result_q : 32'd0;
    assign div_start       = (state_q == ST_ISSUE);
    assign div_numerator   = num_q;
    assign div_denominator = den_q;
    assign stall           = req_valid & ~resp_valid & ~flush;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural variable-latency
// unsigned divider. Expected results come from a RISC-V reference function
// and are queued when each request is driven.
module tb_div_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] result;
    logic        div_start;
    logic [31:0] div_numerator;
    logic [31:0] div_denominator;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_resp;

    int test_cnt  = 0;
    int fail_cnt  = 0;
    int start_cnt = 0;
    int div_lat   = 3;
    int cnt;
    logic [31:0] mq;
    logic [31:0] mr;
    logic [31:0] exp_q[$];
    logic [31:0] last_num;
    logic [31:0] last_den;
    bit          cache_ok = 1'b0;
    logic [31:0] ck_a;
    logic [31:0] ck_b;
    bit          ck_s;
`ifdef DIV_REM_FUSE_EN
    bit fuse_en = 1'b1;
`else
    bit fuse_en = 1'b0;
`endif

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .funct3         (funct3),
        .rs1            (rs1),
        .rs2            (rs2),
        .flush          (flush),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .result         (result),
        .div_start      (div_start),
        .div_numerator  (div_numerator),
        .div_denominator(div_denominator),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .div_resp       (div_resp)
    );

    // Divider model: done pulse div_lat cycles after the start pulse; shares the reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 0;
            div_resp <= 1'b0;
            mq       <= 32'd0;
            mr       <= 32'd0;
        end else if (div_start) begin
            cnt      <= div_lat;
            div_resp <= 1'b0;
            mq       <= div_numerator / div_denominator;
            mr       <= div_numerator % div_denominator;
        end else begin
            div_resp <= (cnt == 1);
            if (cnt != 0) cnt <= cnt - 1;
        end
    end
    assign div_quotient  = mq;
    assign div_remainder = mr;

    // Count divider start pulses.
    always @(posedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
    end

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (f)
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            3'b111: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        test_cnt++;
        assert (obs === want) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic check_resp(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, ":unexpected_resp"}, 32'(exp_q.size()), 32'd1);
        end else begin
            check({tag, ":result"}, result, exp_q.pop_front());
        end
        check({tag, ":stall_at_resp"}, 32'(stall), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        bit spec;
        bit hit;
        bit got;
        int lat;
        int s0;
        int exp_lat;
        int exp_st;
        sgn  = ~f[2] ? 1'b0 : ~f[0];
        spec = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (a == 32'd0);
        hit  = !spec && fuse_en && cache_ok && (a == ck_a) && (b == ck_b) && (sgn == ck_s);
        exp_lat = (spec || hit) ? 1 : 3 + div_lat;
        exp_st  = (spec || hit) ? 0 : 1;
        if (!spec && !hit) begin
            cache_ok = 1'b1;
            ck_a = a;
            ck_b = b;
            ck_s = sgn;
        end
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = f;
        rs1       = a;
        rs2       = b;
        exp_q.push_back(ref_res(f, a, b));
        s0  = start_cnt;
        lat = 0;
        got = 1'b0;
        #1;
        check({tag, ":stall"}, 32'(stall), 32'd1);
        check({tag, ":result_idle"}, result, 32'd0);
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            #1;
            if (div_resp) begin
                last_num = div_numerator;
                last_den = div_denominator;
            end
            if (resp_valid) begin
                got = 1'b1;
                check_resp(tag);
            end
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":starts"}, 32'(start_cnt - s0), 32'(exp_st));
    endtask

    initial begin
        int  s0;
        int  n;
        bit  seen;
        bit  got;
        bit  saw_dresp;
        bit  early;
        rst = 1'b0; req_valid = 1'b0; flush = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset:stall", 32'(stall), 32'd0);
        check("reset:resp_valid", 32'(resp_valid), 32'd0);
        check("reset:result", result, 32'd0);
        check("reset:div_start", 32'(div_start), 32'd0);
        check("reset:num", div_numerator, 32'd0);
        check("reset:den", div_denominator, 32'd0);
        req_valid = 1'b1; #1;
        check("reset:stall_follows", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;

        div_lat = 3;
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7);
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2:num", last_num, 32'd7);
        check("div_m7_2:den", last_den, 32'd2);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2);
        do_op("div_5_0",    3'b100, 32'd5, 32'd0);
        do_op("remu_5_0",   3'b111, 32'd5, 32'd0);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("divu_0_5",   3'b101, 32'd0, 32'd5);
        div_lat = 1;
        do_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE);

        // Non-divide funct3 is not a request.
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b011; rs1 = 32'd100; rs2 = 32'd7;
        s0 = start_cnt; seen = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("bad_funct3:resp", 32'(seen), 32'd0);
        check("bad_funct3:starts", 32'(start_cnt - s0), 32'd0);
        req_valid = 1'b0;

        // Flush three cycles into WAIT, then a new request held off until the drain completes.
        div_lat = 8;
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
        s0 = start_cnt;
        repeat (4) @(negedge clk);
        flush = 1'b1; req_valid = 1'b0; cache_ok = 1'b0;
        #1;
        check("flush:resp_valid", 32'(resp_valid), 32'd0);
        check("flush:stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b1; funct3 = 3'b100; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7;
        exp_q.push_back(ref_res(3'b100, 32'hFFFF_FF9C, 32'd7));
        cache_ok = 1'b1; ck_a = 32'hFFFF_FF9C; ck_b = 32'd7; ck_s = 1'b1;
        saw_dresp = 1'b0; early = 1'b0; got = 1'b0; n = 0;
        #1;
        while (!got && n < 200) begin
            if (div_resp) saw_dresp = 1'b1;
            if (div_start && !saw_dresp) early = 1'b1;
            if (resp_valid) begin
                got = 1'b1;
                check_resp("flush_next");
            end else begin
                @(negedge clk); n++; #1;
            end
        end
        check("flush:held_off", 32'(early), 32'd0);
        check("flush:drain_seen", 32'(saw_dresp), 32'd1);
        check("flush:starts", 32'(start_cnt - s0), 32'd2);

        // Reset asserted while waiting on the divider.
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_wait:resp_valid", 32'(resp_valid), 32'd0);
        check("rst_wait:result", result, 32'd0);
        check("rst_wait:div_start", 32'(div_start), 32'd0);
        check("rst_wait:num", div_numerator, 32'd0);
        check("rst_wait:den", div_denominator, 32'd0);
        check("rst_wait:stall", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; cache_ok = 1'b0;
        div_lat = 2;
        do_op("divu_9_3", 3'b101, 32'd9, 32'd3);

        // DIV then REM on identical operands.
        do_op("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9);
        do_op("rem_100_m7", 3'b110, 32'd100, 32'hFFFF_FFF9);

        @(negedge clk);
        req_valid = 1'b0;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
